// File: rtl/scr1_ialu_mdu_seq_if.sv
// ---------------------------------------------------------------------------
// scr1_ialu_mdu_seq_if
// Command/result bundle between the IALU execute stage and the iterative
// multiply/divide sequencer.
//   cmd_vd_i  : command valid, held by the pipeline until res_rdy_o
//   cmd_i     : 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op1_i     : rs1 operand (multiplicand / dividend)
//   op2_i     : rs2 operand (multiplier / divisor)
//   kill_i    : pipeline flush
//   busy_o    : sequencer not idle
//   res_rdy_o : one-cycle completion strobe
//   res_o     : result, valid with res_rdy_o, held otherwise
// master = execute stage, slave = sequencer.
// ---------------------------------------------------------------------------
interface scr1_ialu_mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            cmd_vd_i;
    logic [2:0]      cmd_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic            kill_i;
    logic            busy_o;
    logic            res_rdy_o;
    logic [XLEN-1:0] res_o;

    modport master (
        output cmd_vd_i, cmd_i, op1_i, op2_i, kill_i,
        input  busy_o, res_rdy_o, res_o
    );

    modport slave (
        input  cmd_vd_i, cmd_i, op1_i, op2_i, kill_i,
        output busy_o, res_rdy_o, res_o
    );
endinterface

// File: rtl/scr1_ialu_mdu_seq.sv
// ---------------------------------------------------------------------------
// scr1_ialu_mdu_seq
// Iterative RV32M sequencer: radix-2 shift-add multiply or restoring divide
// over XLEN cycles on operand magnitudes, followed by one sign-correction
// cycle and a one-cycle completion strobe.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   mdu   : command/result bundle (slave side), see scr1_ialu_mdu_seq_if
// ---------------------------------------------------------------------------
module scr1_ialu_mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    scr1_ialu_mdu_seq_if.slave       mdu
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_CORR = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] CMD_MUL    = 3'd0;
    localparam logic [2:0] CMD_MULH   = 3'd1;
    localparam logic [2:0] CMD_MULHSU = 3'd2;
    localparam logic [2:0] CMD_DIV    = 3'd4;
    localparam logic [2:0] CMD_REM    = 3'd6;
    localparam logic [2:0] CMD_REMU   = 3'd7;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_cmd;
    logic            r_neg;
    logic [XLEN-1:0] r_opnd;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] r_acc_hi;   // product high half / partial remainder
    logic [XLEN-1:0] r_acc_lo;   // multiplier->product low / dividend->quotient
    logic [XLEN-1:0] r_res_new;  // result being delivered in DONE
    logic [XLEN-1:0] r_res_hold; // last delivered result

    // ---------------- accept-time decode ----------------
    logic            w_accept;
    logic            w_op1_signed, w_op2_signed;
    logic            w_sign1, w_sign2, w_neg;
    logic [XLEN-1:0] w_mag1, w_mag2;
    logic            w_div_zero, w_div_ovf, w_fast;
    logic [XLEN-1:0] w_fast_res;

    assign w_accept     = (r_state == ST_IDLE) && mdu.cmd_vd_i && !mdu.kill_i;
    assign w_op1_signed = (mdu.cmd_i == CMD_MULH) || (mdu.cmd_i == CMD_MULHSU) ||
                          (mdu.cmd_i == CMD_DIV)  || (mdu.cmd_i == CMD_REM);
    assign w_op2_signed = (mdu.cmd_i == CMD_MULH) || (mdu.cmd_i == CMD_DIV) ||
                          (mdu.cmd_i == CMD_REM);
    assign w_sign1      = w_op1_signed && mdu.op1_i[XLEN-1];
    assign w_sign2      = w_op2_signed && mdu.op2_i[XLEN-1];
    assign w_mag1       = w_sign1 ? -mdu.op1_i : mdu.op1_i;
    assign w_mag2       = w_sign2 ? -mdu.op2_i : mdu.op2_i;
    // Remainder takes the dividend's sign; everything else the product of signs.
    assign w_neg        = ((mdu.cmd_i == CMD_REM) || (mdu.cmd_i == CMD_REMU)) ?
                          w_sign1 : (w_sign1 ^ w_sign2);

    assign w_div_zero = mdu.cmd_i[2] && (mdu.op2_i == '0);
    assign w_div_ovf  = ((mdu.cmd_i == CMD_DIV) || (mdu.cmd_i == CMD_REM)) &&
                        (mdu.op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&mdu.op2_i);
    assign w_fast     = w_div_zero || w_div_ovf;
    // cmd_i[1] separates REM* from DIV* among divide commands.
    assign w_fast_res = w_div_zero ? (mdu.cmd_i[1] ? mdu.op1_i : {XLEN{1'b1}}) :
                                     (mdu.cmd_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}});

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ge;
    logic [XLEN-1:0] w_hi_next, w_lo_next;

    assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_div_shift = {r_acc_hi, r_acc_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    // Shifted remainder is always < 2*divisor, so bit XLEN of the difference
    // is exactly the borrow.
    assign w_div_ge    = !w_div_diff[XLEN];

    assign w_hi_next = r_cmd[2] ? (w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0])
                                : w_mul_sum[XLEN:1];
    assign w_lo_next = r_cmd[2] ? {r_acc_lo[XLEN-2:0], w_div_ge}
                                : {w_mul_sum[0], r_acc_lo[XLEN-1:1]};

    // ---------------- sign correction ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_c;
    logic [XLEN-1:0]   w_div_sel, w_div_c, w_corr_res;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_c   = r_neg ? -w_prod : w_prod;
    assign w_div_sel  = r_cmd[1] ? r_acc_hi : r_acc_lo;
    assign w_div_c    = r_neg ? -w_div_sel : w_div_sel;
    assign w_corr_res = r_cmd[2] ? w_div_c :
                        (r_cmd == CMD_MUL) ? w_prod_c[XLEN-1:0] : w_prod_c[2*XLEN-1:XLEN];

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_neg      <= 1'b0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_res_new  <= '0;
            r_res_hold <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd <= mdu.cmd_i;
                        r_neg <= w_neg;
                        r_cnt <= '0;
                        if (w_fast) begin
                            r_res_new <= w_fast_res;
                            r_state   <= ST_DONE;
                        end else begin
                            r_state  <= ST_ITER;
                            r_acc_hi <= '0;
                            r_opnd   <= mdu.cmd_i[2] ? w_mag2 : w_mag1;
                            r_acc_lo <= mdu.cmd_i[2] ? w_mag1 : w_mag2;
                        end
                    end
                end
                ST_ITER: begin
                    if (mdu.kill_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc_hi <= w_hi_next;
                        r_acc_lo <= w_lo_next;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CW'(XLEN-1)) begin
                            r_state <= ST_CORR;
                        end
                    end
                end
                ST_CORR: begin
                    if (mdu.kill_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_res_new <= w_corr_res;
                        r_state   <= ST_DONE;
                    end
                end
                default: begin // ST_DONE
                    r_state <= ST_IDLE;
                    if (!mdu.kill_i) begin
                        r_res_hold <= r_res_new;
                    end
                end
            endcase
        end
    end

    // A kill in DONE suppresses both the strobe and the result update.
    logic w_deliver;
    assign w_deliver     = (r_state == ST_DONE) && !mdu.kill_i;
    assign mdu.busy_o    = (r_state != ST_IDLE);
    assign mdu.res_rdy_o = w_deliver;
    assign mdu.res_o     = w_deliver ? r_res_new : r_res_hold;

endmodule

// File: tb/tb_scr1_ialu_mdu_seq.sv
// ---------------------------------------------------------------------------
// tb_scr1_ialu_mdu_seq
// Directed vectors for the iterative multiply/divide sequencer. The driver
// pushes the expected result and latency for each accepted command; a
// monitor pops and compares on every res_rdy_o strobe.
// ---------------------------------------------------------------------------
module tb_scr1_ialu_mdu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_strobes = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];

    scr1_ialu_mdu_seq_if #(.XLEN(32)) mif ();

    scr1_ialu_mdu_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp_v);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard head.
    always @(negedge clk) begin
        if (mif.res_rdy_o === 1'b1) begin
            exp_t t;
            n_strobes++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=0x%08h required=none", mif.res_o);
            end else begin
                t = sb.pop_front();
                $display("txn %s res=0x%08h lat=%0d", t.name, mif.res_o, cyc - t.acc + 1);
                chk({t.name, "_res"}, mif.res_o, t.res);
                chk({t.name, "_lat"}, 32'(cyc - t.acc + 1), 32'(t.lat));
            end
        end
    end

    task automatic wait_done(input int lat, input string nm);
        int busy_n = 0;
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mif.busy_o === 1'b1) busy_n++;
            if (mif.res_rdy_o === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_strobe required=strobe", nm);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(lat));
        @(posedge clk); #1;
        mif.cmd_vd_i = 1'b0;
    endtask

    // Drive a command, which the idle DUT accepts at the next edge, then
    // scramble the operands to show they are not re-sampled.
    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input string nm);
        exp_t t;
        mif.cmd_vd_i = 1'b1;
        mif.cmd_i    = c;
        mif.op1_i    = a;
        mif.op2_i    = b;
        @(posedge clk); #1;
        t.res = e; t.lat = lat; t.acc = cyc; t.name = nm;
        sb.push_back(t);
        mif.op1_i = $urandom;
        mif.op2_i = $urandom;
        wait_done(lat, nm);
    endtask

    task automatic idle_no_strobe(input int n, input string nm);
        int s0 = n_strobes;
        repeat (n) @(posedge clk);
        #1;
        chk(nm, 32'(n_strobes - s0), 32'd0);
    endtask

    initial begin
        mif.cmd_vd_i = 1'b0;
        mif.cmd_i    = 3'd0;
        mif.op1_i    = '0;
        mif.op2_i    = '0;
        mif.kill_i   = 1'b0;
        #3;
        chk("rst_busy",    {31'd0, mif.busy_o},    32'd0);
        chk("rst_res_rdy", {31'd0, mif.res_rdy_o}, 32'd0);
        chk("rst_res",     mif.res_o,              32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Multiply
        issue(3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3");
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_ff");
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, "mulh_ff");
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_ff");
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, "mul_ff");
        // Divide
        issue(3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, "div_m7_2");
        issue(3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, "rem_m7_2");
        issue(3'd5, 32'h00000007, 32'h00000002, 32'h00000003, 34, "divu_7_2");
        issue(3'd7, 32'h00000007, 32'h00000002, 32'h00000001, 34, "remu_7_2");
        // Same bit patterns as the overflow case, unsigned: full iteration
        issue(3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, "divu_min_ff");
        issue(3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "remu_min_ff");
        // Fast paths
        issue(3'd5, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1, "divu_by0");
        issue(3'd7, 32'h12345678, 32'h00000000, 32'h12345678, 1, "remu_by0");
        issue(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        issue(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_ovf");

        // Kill in ITER at cnt=10
        mif.cmd_vd_i = 1'b1; mif.cmd_i = 3'd0;
        mif.op1_i = 32'h00001234; mif.op2_i = 32'h00005678;
        @(posedge clk); #1;                 // accepted, cnt=0
        repeat (10) @(posedge clk);
        #1;                                 // cnt=10
        chk("kill_busy_before", {31'd0, mif.busy_o}, 32'd1);
        mif.kill_i = 1'b1; mif.cmd_vd_i = 1'b0;
        @(posedge clk); #1;
        mif.kill_i = 1'b0;
        chk("kill_busy_after", {31'd0, mif.busy_o}, 32'd0);
        chk("kill_res_hold", mif.res_o, 32'h00000000);
        idle_no_strobe(40, "kill_no_strobe");
        issue(3'd3, 32'h00010000, 32'h00010000, 32'h00000001, 34, "mulhu_after_kill");

        // Kill in DONE on a fast path: no strobe, result held
        mif.cmd_vd_i = 1'b1; mif.cmd_i = 3'd5;
        mif.op1_i = 32'hDEADBEEF; mif.op2_i = 32'h0;
        @(posedge clk); #1;                 // accepted, now DONE
        mif.kill_i = 1'b1; mif.cmd_vd_i = 1'b0;
        @(negedge clk);
        chk("killdone_res_rdy", {31'd0, mif.res_rdy_o}, 32'd0);
        chk("killdone_res_hold", mif.res_o, 32'h00000001);
        @(posedge clk); #1;
        chk("killdone_busy", {31'd0, mif.busy_o}, 32'd0);
        // Kill in IDLE blocks acceptance
        mif.cmd_vd_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("kill_idle_busy", {31'd0, mif.busy_o}, 32'd0);
        mif.cmd_vd_i = 1'b0; mif.kill_i = 1'b0;
        idle_no_strobe(5, "kill_idle_no_strobe");

        // Asynchronous reset mid-ITER
        mif.cmd_vd_i = 1'b1; mif.cmd_i = 3'd1;
        mif.op1_i = 32'h7FFFFFFF; mif.op2_i = 32'h7FFFFFFF;
        @(posedge clk); #1;
        mif.cmd_vd_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",    {31'd0, mif.busy_o},    32'd0);
        chk("arst_res_rdy", {31'd0, mif.res_rdy_o}, 32'd0);
        chk("arst_res",     mif.res_o,              32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle_no_strobe(40, "arst_no_strobe");

        // Back-to-back: second command asserted in the IDLE cycle after DONE
        issue(3'd4, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34, "b2b_div_100_m7");
        issue(3'd6, 32'd100, 32'hFFFFFFF9, 32'h00000002, 34, "b2b_rem_100_m7");

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
